// File: rtl/fp_issue_ctrl_if.sv
// fp_issue_ctrl_if: issue, FPU handshake and writeback signals of the FP issue controller
interface fp_issue_ctrl_if;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [14:0] rs_addr_i;
  logic [2:0]  rs_used_i;
  logic [4:0]  rd_addr_i;
  logic        rd_fp_i;
  logic        fpu_in_valid_o;
  logic        fpu_in_ready_i;
  logic        fpu_out_valid_i;
  logic [31:0] fpu_result_i;
  logic        flush_i;
  logic        fpu_flush_o;
  logic        wb_valid_o;
  logic        wb_fp_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] pending_o;
  logic        err_o;
  modport master (
    output issue_valid_i, rs_addr_i, rs_used_i, rd_addr_i, rd_fp_i, fpu_in_ready_i,
           fpu_out_valid_i, fpu_result_i, flush_i,
    input  issue_ready_o, fpu_in_valid_o, fpu_flush_o, wb_valid_o, wb_fp_o, wb_rd_o,
           wb_data_o, stall_o, busy_o, pending_o, err_o
  );
  modport slave (
    input  issue_valid_i, rs_addr_i, rs_used_i, rd_addr_i, rd_fp_i, fpu_in_ready_i,
           fpu_out_valid_i, fpu_result_i, flush_i,
    output issue_ready_o, fpu_in_valid_o, fpu_flush_o, wb_valid_o, wb_fp_o, wb_rd_o,
           wb_data_o, stall_o, busy_o, pending_o, err_o
  );
endinterface

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: FPU issue gating, FP scoreboard, in-order tag FIFO and registered writeback
module fp_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  fp_issue_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;
  state_t          state, state_n;
  logic [CW-1:0]   count, count_n;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [5:0]      fifo [DEPTH];
  logic [31:0]     pending, set_mask, clr_mask;
  logic            hazard, active, can_issue, accept, pop;
  assign hazard = (bus.rs_used_i[0] & pending[bus.rs_addr_i[4:0]])
                | (bus.rs_used_i[1] & pending[bus.rs_addr_i[9:5]])
                | (bus.rs_used_i[2] & pending[bus.rs_addr_i[14:10]])
                | (bus.rd_fp_i & pending[bus.rd_addr_i]);
  assign active         = ~bus.flush_i & (state != FLUSH);
  assign can_issue      = bus.issue_valid_i & ~hazard & (count < CW'(DEPTH)) & active;
  assign accept         = can_issue & bus.fpu_in_ready_i;
  assign pop            = bus.fpu_out_valid_i & (count != '0) & active;
  assign bus.fpu_in_valid_o = can_issue;
  assign bus.issue_ready_o  = accept;
  assign bus.stall_o        = bus.issue_valid_i & ~accept;
  assign bus.fpu_flush_o    = bus.flush_i;
  assign bus.busy_o         = (count != '0) | bus.wb_valid_o;
  assign bus.pending_o      = pending;
  // next state, occupancy and scoreboard set/clear masks
  always_comb begin
    count_n  = count + CW'(accept) - CW'(pop);
    set_mask = (accept & bus.rd_fp_i) ? 32'd1 << bus.rd_addr_i : '0;
    clr_mask = (bus.wb_valid_o & bus.wb_fp_o) ? 32'd1 << bus.wb_rd_o : '0;
    state_n  = bus.flush_i ? FLUSH :
               state == FLUSH ? IDLE :
               accept ? BUSY :
               count_n == '0 ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  // tag storage; pointers live with the rest of the control state
  always_ff @(posedge clk_i) begin
    if (accept) fifo[wr_ptr] <= {bus.rd_fp_i, bus.rd_addr_i};
  end
  // occupancy, pointers, scoreboard, writeback strobe and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pending       <= '0;
      bus.wb_valid_o <= 1'b0;
      bus.wb_fp_o   <= 1'b0;
      bus.wb_rd_o   <= '0;
      bus.wb_data_o <= '0;
      bus.err_o     <= 1'b0;
    end else begin
      bus.wb_valid_o <= pop;
      bus.err_o      <= bus.err_o | (bus.fpu_out_valid_i & (count == '0) & active);
      if (pop) begin
        bus.wb_fp_o   <= fifo[rd_ptr][5];
        bus.wb_rd_o   <= fifo[rd_ptr][4:0];
        bus.wb_data_o <= bus.fpu_result_i;
      end
      if (bus.flush_i) begin
        count   <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        pending <= '0;
      end else begin
        count   <= count_n;
        wr_ptr  <= wr_ptr + AW'(accept);
        rd_ptr  <= rd_ptr + AW'(pop);
        pending <= (pending & ~clr_mask) | set_mask;
      end
    end
  end
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl: directed scoreboard bench for fp_issue_ctrl
module tb_fp_issue_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [5:0]  tag_q [$];
  logic [37:0] exp_q [$];
  fp_issue_ctrl_if b ();
  fp_issue_ctrl #(.DEPTH(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(b));
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic [37:0] e;
    @(posedge clk_i);
    #1;
    if (b.wb_valid_o) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("wb", 64'({b.wb_fp_o, b.wb_rd_o, b.wb_data_o}), 64'(e));
    end
  endtask
  task automatic drive_issue(input logic v, input logic fp, input logic [4:0] rd,
                             input logic [14:0] rs, input logic [2:0] used);
    b.issue_valid_i  = v;
    b.rd_fp_i        = fp;
    b.rd_addr_i      = rd;
    b.rs_addr_i      = rs;
    b.rs_used_i      = used;
    b.fpu_in_ready_i = 1'b1;
  endtask
  task automatic acc(input logic fp, input logic [4:0] rd);
    tag_q.push_back({fp, rd});
  endtask
  task automatic result(input logic [31:0] d);
    logic [5:0] t;
    t = tag_q.pop_front();
    exp_q.push_back({t, d});
    b.fpu_out_valid_i = 1'b1;
    b.fpu_result_i    = d;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    drive_issue(0, 0, 0, 0, 0);
    b.fpu_out_valid_i = 0;
    b.fpu_result_i    = 0;
    b.flush_i         = 0;
    step();
    step();
    chk("rst_wb_valid", 64'(b.wb_valid_o), 0);
    chk("rst_pending", 64'(b.pending_o), 0);
    chk("rst_busy", 64'(b.busy_o), 0);
    chk("rst_err", 64'(b.err_o), 0);
    rst_i = 0;
    // RAW hazard on f3
    drive_issue(1, 1, 3, 0, 0);
    #1;
    chk("raw_ready", 64'(b.issue_ready_o), 1);
    chk("raw_in_valid", 64'(b.fpu_in_valid_o), 1);
    step();
    acc(1, 3);
    chk("raw_pending_set", 64'(b.pending_o), 64'(32'd1 << 3));
    chk("raw_busy", 64'(b.busy_o), 1);
    drive_issue(1, 1, 5, 15'd3, 3'b001);
    result(32'h11);
    #1;
    chk("raw_stall", 64'(b.stall_o), 1);
    chk("raw_in_valid_low", 64'(b.fpu_in_valid_o), 0);
    step();
    b.fpu_out_valid_i = 0;
    chk("raw_wb_strobe", 64'(b.wb_valid_o), 1);
    #1;
    chk("raw_stall_wb_cycle", 64'(b.stall_o), 1);
    chk("raw_pending_held", 64'(b.pending_o), 64'(32'd1 << 3));
    step();
    chk("raw_pending_clr", 64'(b.pending_o), 0);
    chk("raw_ready_n2", 64'(b.issue_ready_o), 1);
    step();
    acc(1, 5);
    b.issue_valid_i = 0;
    chk("raw_pending_f5", 64'(b.pending_o), 64'(32'd1 << 5));
    result(32'h55);
    step();
    b.fpu_out_valid_i = 0;
    step();
    chk("raw_drained", 64'(exp_q.size()), 0);
    chk("raw_idle_busy", 64'(b.busy_o), 0);
    // full occupancy
    for (int i = 0; i < 4; i++) begin
      drive_issue(1, 0, 5'(10 + i), 0, 0);
      #1;
      chk("full_fill_ready", 64'(b.issue_ready_o), 1);
      step();
      acc(0, 5'(10 + i));
    end
    drive_issue(1, 0, 14, 0, 0);
    #1;
    chk("full_stall", 64'(b.stall_o), 1);
    result(32'h100);
    #1;
    chk("full_pop_no_accept", 64'(b.issue_ready_o), 0);
    step();
    result(32'h101);
    #1;
    chk("full_pop_and_accept", 64'(b.issue_ready_o), 1);
    step();
    acc(0, 14);
    b.fpu_out_valid_i = 0;
    drive_issue(1, 0, 15, 0, 0);
    #1;
    chk("full_refill", 64'(b.issue_ready_o), 1);
    step();
    acc(0, 15);
    drive_issue(1, 0, 16, 0, 0);
    #1;
    chk("full_stall_again", 64'(b.stall_o), 1);
    b.issue_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      result(32'h200 + 32'(i));
      step();
      chk("full_b2b_wb", 64'(b.wb_valid_o), 1);
    end
    b.fpu_out_valid_i = 0;
    step();
    chk("full_drained", 64'(exp_q.size()), 0);
    // ordering with an integer destination
    drive_issue(1, 1, 1, 0, 0);
    #1;
    chk("ord_ready_f1", 64'(b.issue_ready_o), 1);
    step();
    acc(1, 1);
    drive_issue(1, 0, 7, 0, 0);
    #1;
    chk("ord_ready_x7", 64'(b.issue_ready_o), 1);
    step();
    acc(0, 7);
    drive_issue(1, 1, 2, 0, 0);
    #1;
    chk("ord_ready_f2", 64'(b.issue_ready_o), 1);
    step();
    acc(1, 2);
    b.issue_valid_i = 0;
    chk("ord_pending", 64'(b.pending_o), 64'(32'h6));
    result(32'hA);
    step();
    result(32'hB);
    step();
    chk("ord_no_bit7", 64'(b.pending_o[7]), 0);
    result(32'hC);
    step();
    b.fpu_out_valid_i = 0;
    step();
    step();
    chk("ord_pending_clr", 64'(b.pending_o), 0);
    chk("ord_drained", 64'(exp_q.size()), 0);
    // flush with three outstanding
    drive_issue(1, 1, 20, 0, 0);
    step();
    acc(1, 20);
    drive_issue(1, 1, 21, 0, 0);
    step();
    acc(1, 21);
    drive_issue(1, 0, 22, 0, 0);
    step();
    acc(0, 22);
    drive_issue(1, 0, 23, 0, 0);
    b.flush_i = 1;
    #1;
    chk("fl_no_accept", 64'(b.issue_ready_o), 0);
    chk("fl_fpu_flush", 64'(b.fpu_flush_o), 1);
    chk("fl_in_valid", 64'(b.fpu_in_valid_o), 0);
    step();
    tag_q.delete();
    b.flush_i         = 0;
    b.fpu_out_valid_i = 1;
    b.fpu_result_i    = 32'hBAD;
    #1;
    chk("fl_state_ready", 64'(b.issue_ready_o), 0);
    chk("fl_pending", 64'(b.pending_o), 0);
    chk("fl_busy", 64'(b.busy_o), 0);
    step();
    b.fpu_out_valid_i = 0;
    chk("fl_stray_wb", 64'(b.wb_valid_o), 0);
    chk("fl_stray_err", 64'(b.err_o), 0);
    #1;
    chk("fl_idle_ready", 64'(b.issue_ready_o), 1);
    step();
    acc(0, 23);
    b.issue_valid_i = 0;
    result(32'h23);
    step();
    b.fpu_out_valid_i = 0;
    step();
    chk("fl_drained", 64'(exp_q.size()), 0);
    // protocol error: result with nothing outstanding
    b.fpu_out_valid_i = 1;
    b.fpu_result_i    = 32'hDEAD;
    step();
    b.fpu_out_valid_i = 0;
    chk("err_no_wb", 64'(b.wb_valid_o), 0);
    chk("err_set", 64'(b.err_o), 1);
    step();
    step();
    chk("err_sticky", 64'(b.err_o), 1);
    // reset mid-traffic
    drive_issue(1, 1, 9, 0, 0);
    step();
    rst_i = 1;
    step();
    step();
    tag_q.delete();
    exp_q.delete();
    rst_i = 0;
    b.issue_valid_i = 0;
    chk("rst2_wb_valid", 64'(b.wb_valid_o), 0);
    chk("rst2_wb_data", 64'(b.wb_data_o), 0);
    chk("rst2_wb_rd", 64'({b.wb_fp_o, b.wb_rd_o}), 0);
    chk("rst2_pending", 64'(b.pending_o), 0);
    chk("rst2_err", 64'(b.err_o), 0);
    chk("rst2_busy", 64'(b.busy_o), 0);
    drive_issue(1, 1, 9, 0, 0);
    #1;
    chk("rst2_ready", 64'(b.issue_ready_o), 1);
    step();
    acc(1, 9);
    b.issue_valid_i = 0;
    result(32'h99);
    step();
    b.fpu_out_valid_i = 0;
    step();
    chk("rst2_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
